mem_arbiter: RTL

//  Shares the single unified instruction/data memory between two requesters:
//  - m0: multicycle CPU, driven by the FSM memory states (fetch, load, store).
//  - m1: debug/program loader.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU (m0) and the
// debug loader (m1); one transaction in flight, aborted after TIMEOUT cycles.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_gnt,
  output logic            m0_done,
  output logic            m0_err,
  output logic [DW-1:0]   m0_rdata,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_gnt,
  output logic            m1_done,
  output logic            m1_err,
  output logic [DW-1:0]   m1_rdata,

  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last;         // 1: m1 won the previous grant, so m0 wins a tie
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          finish;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign finish      = mem_req && (mem_ack || timeout_hit);
  assign mem_req     = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // No acceptance while reset is held: nothing would be captured.
        if (!rst) begin
          m0_gnt = m0_req && (!m1_req || last);
          m1_gnt = m1_req && (!m0_req || !last);
        end
        if (m0_gnt)      state_nxt = BUSY0;
        else if (m1_gnt) state_nxt = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (mem_ack || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      m0_done   <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_done   <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      if (m0_gnt) begin
        mem_we    <= m0_we;
        mem_addr  <= m0_addr;
        mem_wdata <= m0_wdata;
        mem_be    <= m0_be;
        last      <= 1'b0;
        cnt       <= '0;
      end else if (m1_gnt) begin
        mem_we    <= m1_we;
        mem_addr  <= m1_addr;
        mem_wdata <= m1_wdata;
        mem_be    <= m1_be;
        last      <= 1'b1;
        cnt       <= '0;
      end else if (finish) begin
        // An ack on the timeout edge wins: err only when no ack arrived.
        if (state == BUSY0) begin
          m0_done <= 1'b1;
          m0_err  <= !mem_ack;
          if (mem_ack && !mem_we) m0_rdata <= mem_rdata;
        end else begin
          m1_done <= 1'b1;
          m1_err  <= !mem_ack;
          if (mem_ack && !mem_we) m1_rdata <= mem_rdata;
        end
      end else if (mem_req) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
